// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants and types for the ID-stage control pipe
//  Contents:
//    IS_*      control word width and bit positions
//    OP2_*     operand2 mode encodings, SIZE_* transfer size encodings
//    ALU_*     ALU op codes used by load/store address generation
//    COND_*    ARM condition field codes
//    ctrl_class_t  instruction class (CLASS_DP, CLASS_LS, CLASS_BR, CLASS_UNK)
//    ctrl_stage_t  one registered control stage {is, rd, vld}
package ctrl_pkg;

  localparam int IS_W = 13;

  localparam int IS_OP2_LO = 0;   // [1:0] operand2 mode
  localparam int IS_SIZE_LO = 2;  // [3:2] transfer size
  localparam int IS_MEM_WR = 4;
  localparam int IS_MEM_EN = 5;
  localparam int IS_RF_WR = 6;
  localparam int IS_LOAD = 7;
  localparam int IS_ALU_LO = 8;   // [11:8] ALU op
  localparam int IS_SHIFT = 12;

  localparam logic [IS_W-1:0] IS_NOP = '0;

  localparam logic [1:0] OP2_IMM = 2'b00;
  localparam logic [1:0] OP2_REG = 2'b01;
  localparam logic [1:0] OP2_LS_IMM = 2'b10;
  localparam logic [1:0] OP2_LS_REG = 2'b11;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b00;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    CLASS_DP  = 2'd0,
    CLASS_LS  = 2'd1,
    CLASS_BR  = 2'd2,
    CLASS_UNK = 2'd3
  } ctrl_class_t;

  typedef struct packed {
    logic [IS_W-1:0] is;
    logic [3:0]      rd;
    logic            vld;
  } ctrl_stage_t;

  // Class from IR[27:25]; everything outside DP/LS/branch is left undecoded.
  function automatic ctrl_class_t classify(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: classify = CLASS_DP;
      3'b010, 3'b011: classify = CLASS_LS;
      3'b101:         classify = CLASS_BR;
      default:        classify = CLASS_UNK;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_pipe_unit_cond_eval.sv
// rtl/ctrl_pipe_unit_cond_eval.sv - ARM condition field evaluation (combinational)
//  Ports:
//    cond   in   4   condition field, IR[31:28]
//    flags  in   4   {N,Z,C,V}
//    ok     out  1   condition passes
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       ok
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    ok = 1'b0;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_CS: ok = c;
      COND_CC: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !c || z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = z || (n != v);
      COND_AL: ok = 1'b1;
      COND_NV: ok = 1'b0;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - ID-stage control decoder plus STAGES-deep control register chain
//  Optional feature macro: CTRL_PERF_CNT_EN (adds CNT_W parameter and stall/flush counters).
//  Parameters:
//    STAGES   registered stages after ID (1..4); stage 0 = EX
//    CNT_W    counter width (CTRL_PERF_CNT_EN only)
//  Ports:
//    clk, reset    clock, asynchronous active-high reset
//    ir            instruction in the IF/ID register
//    flags         {N,Z,C,V}
//    hold          global freeze
//    id_is         decoded control word of the ID instruction
//    id_branch     taken branch in ID
//    id_rf_clear   live non-branch instruction in ID
//    stall_out     hold PC and IF/ID
//    flush_if      discard IF/ID on the next edge
//    stage_is      per-stage control words, stage k at [13k+:13]
//    stage_rd      per-stage destination register
//    stage_vld     per-stage valid
//    stall_cnt     hazard stall count, saturating (CTRL_PERF_CNT_EN only)
//    flush_cnt     flush count, saturating (CTRL_PERF_CNT_EN only)
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int STAGES = 3
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ir,
  input  logic [3:0]             flags,
  input  logic                   hold,
  output logic [IS_W-1:0]        id_is,
  output logic                   id_branch,
  output logic                   id_rf_clear,
  output logic                   stall_out,
  output logic                   flush_if,
  output logic [IS_W*STAGES-1:0] stage_is,
  output logic [4*STAGES-1:0]    stage_rd,
  output logic [STAGES-1:0]      stage_vld
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
`endif
);

  ctrl_class_t             cls;
  logic                    cond_ok;
  logic                    live;
  logic [IS_W-1:0]         dec_is;
  logic                    is_op;
  logic                    is_branch;
  logic                    reg_form;
  logic                    is_store;
  logic                    hazard;
  ctrl_stage_t             stage0_d;
  ctrl_stage_t [STAGES-1:0] stage_q;

  cond_eval u_cond_eval (
    .cond  (ir[31:28]),
    .flags (flags),
    .ok    (cond_ok)
  );

  assign cls  = classify(ir[27:25]);
  assign live = (ir != 32'd0) && cond_ok;

  // Raw decode, independent of the condition; gated by live below.
  always_comb begin
    dec_is    = IS_NOP;
    is_op     = 1'b0;
    is_branch = 1'b0;
    reg_form  = 1'b0;
    is_store  = 1'b0;
    case (cls)
      CLASS_DP: begin
        is_op    = 1'b1;
        reg_form = !ir[25];
        dec_is[IS_OP2_LO +: 2] = ir[25] ? OP2_IMM : OP2_REG;
        dec_is[IS_ALU_LO +: 4] = ir[24:21];
        // TST/TEQ/CMP/CMN (opcode 10xx) only set flags.
        dec_is[IS_RF_WR] = (ir[24:23] != 2'b10);
        // Shifter only needed for a non-zero rotate or a non-trivial register shift.
        dec_is[IS_SHIFT] = ir[25] ? (|ir[11:8]) : (|ir[11:4]);
      end
      CLASS_LS: begin
        is_op    = 1'b1;
        reg_form = ir[25];
        is_store = !ir[20];
        dec_is[IS_OP2_LO +: 2]  = ir[25] ? OP2_LS_REG : OP2_LS_IMM;
        dec_is[IS_SIZE_LO +: 2] = ir[22] ? SIZE_BYTE : SIZE_WORD;
        dec_is[IS_MEM_WR] = !ir[20];
        dec_is[IS_MEM_EN] = 1'b1;
        dec_is[IS_RF_WR]  = ir[20];
        dec_is[IS_LOAD]   = ir[20];
        dec_is[IS_ALU_LO +: 4] = ir[23] ? ALU_ADD : ALU_SUB;
        dec_is[IS_SHIFT]  = 1'b1;
      end
      CLASS_BR: is_branch = 1'b1;
      default: ;
    endcase
  end

  // Load in EX whose destination is read by the ID instruction.
  assign hazard = stage_q[0].vld && stage_q[0].is[IS_LOAD] &&
                  ((stage_q[0].rd == ir[19:16]) ||
                   (reg_form && (stage_q[0].rd == ir[3:0])) ||
                   (is_store && (stage_q[0].rd == ir[15:12])));

  assign id_is       = (live && is_op) ? dec_is : IS_NOP;
  assign id_rf_clear = live && is_op;
  assign id_branch   = live && is_branch && !hazard;
  assign stall_out   = hold || hazard;
  assign flush_if    = id_branch && !hold;

  always_comb begin
    stage0_d = '0;
    if (!hazard) begin
      stage0_d.is  = id_is;
      stage0_d.rd  = ir[15:12];
      stage0_d.vld = id_rf_clear;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ctrl_stage_t q;

    if (k == 0) begin : g_head
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (!hold) begin
          q <= stage0_d;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (!hold) begin
          q <= stage_q[k-1];
        end
      end
    end

    assign stage_q[k]               = q;
    assign stage_is[k*IS_W +: IS_W] = q.is;
    assign stage_rd[k*4 +: 4]       = q.rd;
    assign stage_vld[k]             = q.vld;
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && !hold && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_if && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - self-checking bench for ctrl_pipe_unit
module tb_ctrl_pipe_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        hold;
  logic [12:0] id_is;
  logic        id_branch;
  logic        id_rf_clear;
  logic        stall_out;
  logic        flush_if;
  logic [38:0] stage_is;
  logic [11:0] stage_rd;
  logic [2:0]  stage_vld;
`ifdef CTRL_PERF_CNT_EN
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef CTRL_PERF_CNT_EN
  ctrl_pipe_unit #(.STAGES(3), .CNT_W(4)) dut (
`else
  ctrl_pipe_unit #(.STAGES(3)) dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .ir          (ir),
    .flags       (flags),
    .hold        (hold),
    .id_is       (id_is),
    .id_branch   (id_branch),
    .id_rf_clear (id_rf_clear),
    .stall_out   (stall_out),
    .flush_if    (flush_if),
    .stage_is    (stage_is),
    .stage_rd    (stage_rd),
    .stage_vld   (stage_vld)
`ifdef CTRL_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [12:0] is;
    logic        br;
    logic        rfc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold  = 1'b0;
    ir    = 32'd0;
    flags = 4'd0;
    step();
    reset = 1'b0;
  endtask

  localparam logic [31:0] I_ADD   = 32'hE0821003;  // ADD R1,R2,R3
  localparam logic [31:0] I_LDR   = 32'hE5921004;  // LDR R1,[R2,#4]
  localparam logic [31:0] I_ADD4  = 32'hE0814005;  // ADD R4,R1,R5
  localparam logic [31:0] I_B     = 32'hEA000004;  // B
  localparam logic [31:0] I_MOV   = 32'hE3A02001;  // MOV R2,#1

  logic [38:0] full_exp;

  initial begin
    // Watchdog so the run always terminates.
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'hE0821003, 4'h0, 13'h0441, 1'b0, 1'b1};
    vecs[1]  = '{32'hE5921004, 4'h0, 13'h14EA, 1'b0, 1'b1};
    vecs[2]  = '{32'hE5021004, 4'h0, 13'h123A, 1'b0, 1'b1};
    vecs[3]  = '{32'hE7D21003, 4'h0, 13'h14E3, 1'b0, 1'b1};
    vecs[4]  = '{32'hE3510005, 4'h0, 13'h0A00, 1'b0, 1'b1};
    vecs[5]  = '{32'hE0821103, 4'h0, 13'h1441, 1'b0, 1'b1};
    vecs[6]  = '{32'h13A00001, 4'h4, 13'h0000, 1'b0, 1'b0};
    vecs[7]  = '{32'h13A00001, 4'h0, 13'h0D40, 1'b0, 1'b1};
    vecs[8]  = '{32'hEA000004, 4'h0, 13'h0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h0A000004, 4'h0, 13'h0000, 1'b0, 1'b0};
    vecs[10] = '{32'h0A000004, 4'h4, 13'h0000, 1'b1, 1'b0};
    vecs[11] = '{32'h00000000, 4'h0, 13'h0000, 1'b0, 1'b0};
    vecs[12] = '{32'hF0821003, 4'h0, 13'h0000, 1'b0, 1'b0};
    vecs[13] = '{32'hEE000000, 4'h0, 13'h0000, 1'b0, 1'b0};
    vecs[14] = '{32'hCA000004, 4'h9, 13'h0000, 1'b1, 1'b0};
    vecs[15] = '{32'hCA000004, 4'h8, 13'h0000, 1'b0, 1'b0};
    vecs[16] = '{32'h4A000000, 4'h8, 13'h0000, 1'b1, 1'b0};

    reset = 1'b1;
    hold  = 1'b0;
    ir    = 32'd0;
    flags = 4'd0;
    #2;
    chk("reset_vld", 64'(stage_vld), 64'h0);
    chk("reset_is", 64'(stage_is), 64'h0);
    chk("reset_rd", 64'(stage_rd), 64'h0);

    // Decode table; reset held so stage 0 is empty and no hazard can fire.
    for (int i = 0; i < 17; i++) begin
      ir    = vecs[i].ir;
      flags = vecs[i].flags;
      #1;
      chk($sformatf("v%0d_id_is", i), 64'(id_is), 64'(vecs[i].is));
      chk($sformatf("v%0d_branch", i), 64'(id_branch), 64'(vecs[i].br));
      chk($sformatf("v%0d_rf_clear", i), 64'(id_rf_clear), 64'(vecs[i].rfc));
      chk($sformatf("v%0d_flush", i), 64'(flush_if), 64'(vecs[i].br));
    end

    // ADD latency through the chain.
    do_reset();
    ir = I_ADD;
    step();
    chk("add_s0_is", 64'(stage_is[12:0]), 64'h441);
    chk("add_s0_vld", 64'(stage_vld[0]), 64'h1);
    chk("add_s0_rd", 64'(stage_rd[3:0]), 64'h1);
    ir = 32'd0;
    step();
    step();
    chk("add_s2_is", 64'(stage_is[38:26]), 64'h441);
    chk("add_s2_vld", 64'(stage_vld[2]), 64'h1);
    chk("add_s2_rd", 64'(stage_rd[11:8]), 64'h1);
    chk("add_s0_empty", 64'(stage_vld[0]), 64'h0);

    // Load-use stall.
    do_reset();
    ir = I_LDR;
    #1;
    chk("ldr_no_stall", 64'(stall_out), 64'h0);
    step();
    ir = I_ADD4;
    #1;
    chk("ldr_s0_is", 64'(stage_is[12:0]), 64'h14EA);
    chk("lu_stall", 64'(stall_out), 64'h1);
    step();
    chk("lu_bubble_vld", 64'(stage_vld[0]), 64'h0);
    chk("lu_bubble_is", 64'(stage_is[12:0]), 64'h0);
    chk("lu_s1_is", 64'(stage_is[25:13]), 64'h14EA);
    chk("lu_stall_gone", 64'(stall_out), 64'h0);
    step();
    chk("lu_add_is", 64'(stage_is[12:0]), 64'h441);
    chk("lu_add_rd", 64'(stage_rd[3:0]), 64'h4);

    // Hazard source selection with LDR R1 sitting in stage 0.
    do_reset();
    ir = I_LDR;
    step();
    ir = 32'hE5021004; #1;  // STR R1,[R2,#-4]: Rd is a source
    chk("hz_store_rd", 64'(stall_out), 64'h1);
    ir = 32'hE0824001; #1;  // ADD R4,R2,R1: Rm
    chk("hz_rm_reg", 64'(stall_out), 64'h1);
    ir = 32'hE2824001; #1;  // ADD R4,R2,#1: low bits are not Rm
    chk("hz_rm_imm", 64'(stall_out), 64'h0);
    ir = 32'hE0821003; #1;  // ADD R1,R2,R3: Rd of non-store not a source
    chk("hz_rd_nonstore", 64'(stall_out), 64'h0);
    ir = 32'hEA010000; #1;  // B with IR[19:16]=1
    chk("hz_br_stall", 64'(stall_out), 64'h1);
    chk("hz_br_branch", 64'(id_branch), 64'h0);
    chk("hz_br_flush", 64'(flush_if), 64'h0);

    // Taken branch.
    do_reset();
    ir = I_B;
    #1;
    chk("b_branch", 64'(id_branch), 64'h1);
    chk("b_flush", 64'(flush_if), 64'h1);
    chk("b_is", 64'(id_is), 64'h0);
    step();
    chk("b_s0_vld", 64'(stage_vld[0]), 64'h0);

    // Hold with full pipe, then reset mid-hold.
    do_reset();
    ir = I_ADD; step();
    ir = I_LDR; step();
    ir = I_MOV; step();
    full_exp = {13'h441, 13'h14EA, 13'hD40};
    chk("fill_is", 64'(stage_is), 64'(full_exp));
    hold = 1'b1;
    ir = I_B;
    #1;
    chk("hold_stall", 64'(stall_out), 64'h1);
    chk("hold_flush", 64'(flush_if), 64'h0);
    step(); step(); step();
    chk("hold_is", 64'(stage_is), 64'(full_exp));
    chk("hold_vld", 64'(stage_vld), 64'h7);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_vld", 64'(stage_vld), 64'h0);
    chk("async_rst_is", 64'(stage_is), 64'h0);
    hold = 1'b0;

`ifdef CTRL_PERF_CNT_EN
    do_reset();
    chk("cnt_reset", 64'({stall_cnt, flush_cnt}), 64'h0);
    for (int i = 0; i < 20; i++) begin
      ir = I_LDR;
      step();
      ir = I_ADD4;
      step();
    end
    chk("stall_cnt_sat", 64'(stall_cnt), 64'hF);
    chk("flush_cnt_zero", 64'(flush_cnt), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
